// File: rtl/aes_run_ctrl.sv
// Start/busy/done run sequencer for the AES demo: drives encrypt then decrypt round cores.
// Optional build macro AES_RUN_PASS_CNT_EN adds a saturating pass_cnt output.
module aes_run_ctrl #(
    parameter int DATA_W   = 128,
    parameter int RND_W    = 4,
    parameter int DEC_LEAD = 1,
    localparam int BYTES   = DATA_W / 8,
    localparam int SEL_W   = (BYTES > 1) ? $clog2(BYTES) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] plain_in,
    input  logic [DATA_W-1:0] enc_in,
    input  logic [DATA_W-1:0] dec_in,
    output logic              core_clr,
    output logic              enc_run,
    output logic              dec_run,
    output logic [RND_W-1:0]  round,
    output logic [RND_W-1:0]  nr,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              match,
    output logic [DATA_W-1:0] data_out,
    input  logic [SEL_W-1:0]  byte_sel,
    output logic [7:0]        byte_out
`ifdef AES_RUN_PASS_CNT_EN
    ,
    output logic [15:0]       pass_cnt
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_ENC, S_DEC, S_DONE} state_t;

    state_t              r_state,   w_state_nxt;
    logic [RND_W-1:0]    r_round,   w_round_nxt;
    logic [RND_W-1:0]    r_nr,      w_nr_nxt;
    logic [DATA_W-1:0]   r_plain,   w_plain_nxt;
    logic                r_match,   w_match_nxt;
    logic                r_clr,     w_clr_nxt;
    logic                r_enc_run, w_enc_run_nxt;
    logic                r_dec_run, w_dec_run_nxt;
    logic                r_busy,    w_busy_nxt;
    logic                r_done,    w_done_nxt;
    logic                r_err,     w_err_nxt;
    logic [DATA_W-1:0]   w_data;
    logic [7:0]          w_byte;

    // NOTE: every next-state variable gets a default before the case so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_round_nxt = r_round;
        w_nr_nxt    = r_nr;
        w_plain_nxt = r_plain;
        w_match_nxt = r_match;
        w_clr_nxt   = 1'b0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if (mode == 2'd3) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_ENC;
                        w_round_nxt = '0;
                        w_nr_nxt    = RND_W'(10 + 2 * int'(mode));
                        w_plain_nxt = plain_in;
                        w_match_nxt = 1'b0;
                        w_clr_nxt   = 1'b1;
                    end
                end
            end
            S_ENC: begin
                if (r_round == r_nr) begin
                    w_state_nxt = S_DEC;
                    w_round_nxt = '0;
                end else begin
                    w_round_nxt = r_round + 1'b1;
                end
            end
            S_DEC: begin
                if (r_round == r_nr) begin
                    w_state_nxt = S_DONE;
                    w_round_nxt = '0;
                    w_done_nxt  = 1'b1;
                    w_match_nxt = (dec_in == r_plain);
                end else begin
                    w_round_nxt = r_round + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Run-enables are derived from the next state so they line up with the registered round.
        w_enc_run_nxt = (w_state_nxt == S_ENC);
        w_busy_nxt    = (w_state_nxt == S_ENC) || (w_state_nxt == S_DEC);
        w_dec_run_nxt = (w_state_nxt == S_DEC) ||
                        ((w_state_nxt == S_ENC) &&
                         (int'(w_round_nxt) + DEC_LEAD >= int'(w_nr_nxt) + 1));
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_round   <= '0;
            r_nr      <= RND_W'(10);
            r_plain   <= '0;
            r_match   <= 1'b0;
            r_clr     <= 1'b0;
            r_enc_run <= 1'b0;
            r_dec_run <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_round   <= w_round_nxt;
            r_nr      <= w_nr_nxt;
            r_plain   <= w_plain_nxt;
            r_match   <= w_match_nxt;
            r_clr     <= w_clr_nxt;
            r_enc_run <= w_enc_run_nxt;
            r_dec_run <= w_dec_run_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
        end
    end

    always_comb begin
        case (r_state)
            S_IDLE:  w_data = r_plain;
            S_ENC:   w_data = enc_in;
            default: w_data = dec_in;
        endcase
    end

    always_comb begin
        w_byte = 8'h00;
        for (int b = 0; b < BYTES; b++) begin
            if (int'(byte_sel) == b) w_byte = w_data[8*b +: 8];
        end
    end

`ifdef AES_RUN_PASS_CNT_EN
    logic [15:0] r_pass_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pass_cnt <= '0;
        end else if (w_done_nxt && w_match_nxt && (r_pass_cnt != 16'hFFFF)) begin
            r_pass_cnt <= r_pass_cnt + 16'd1;
        end
    end

    assign pass_cnt = r_pass_cnt;
`endif

    assign core_clr = r_clr;
    assign enc_run  = r_enc_run;
    assign dec_run  = r_dec_run;
    assign round    = r_round;
    assign nr       = r_nr;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;
    assign match    = r_match;
    assign data_out = w_data;
    assign byte_out = w_byte;

endmodule

// File: tb/tb_aes_run_ctrl.sv
// Self-checking bench for aes_run_ctrl: vector table, corner sequences and randomized runs
// checked against a cycle-count model of the run timeline.
module tb_aes_run_ctrl;

    localparam int DATA_W   = 128;
    localparam int RND_W    = 4;
    localparam int DEC_LEAD = 1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [1:0]        mode = 2'd0;
    logic [DATA_W-1:0] plain_in = '0;
    logic [DATA_W-1:0] enc_in = '0;
    logic [DATA_W-1:0] dec_in = '0;
    logic [3:0]        byte_sel = '0;
    logic              core_clr, enc_run, dec_run, busy, done, err, match;
    logic [RND_W-1:0]  round, nr;
    logic [DATA_W-1:0] data_out;
    logic [7:0]        byte_out;
`ifdef AES_RUN_PASS_CNT_EN
    logic [15:0]       pass_cnt;
`endif

    aes_run_ctrl #(.DATA_W(DATA_W), .RND_W(RND_W), .DEC_LEAD(DEC_LEAD)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .plain_in(plain_in), .enc_in(enc_in), .dec_in(dec_in),
        .core_clr(core_clr), .enc_run(enc_run), .dec_run(dec_run),
        .round(round), .nr(nr), .busy(busy), .done(done), .err(err),
        .match(match), .data_out(data_out), .byte_sel(byte_sel), .byte_out(byte_out)
`ifdef AES_RUN_PASS_CNT_EN
        , .pass_cnt(pass_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model of what the DUT should be holding between runs.
    int                m_nr = 10;
    logic [DATA_W-1:0] m_plain = '0;
    bit                m_match = 1'b0;
    bit                m_in_done = 1'b0;
    int                m_pass = 0;

    typedef struct {
        logic [1:0]        mode;
        logic [DATA_W-1:0] plain;
        bit                corrupt;
        bit                noise;
        int                exp_nr;
        bit                exp_err;
        bit                exp_match;
        int                exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected outputs k cycles after the accepting edge (k = 1 is the first ENC cycle).
    task automatic check_cycle(input int k, input int n, input logic [DATA_W-1:0] ev,
                               input logic [DATA_W-1:0] dv, input logic [DATA_W-1:0] p);
        int enc_end, dec_end, e_round;
        bit e_enc, e_dec, e_done, e_dec_run, e_match;
        logic [DATA_W-1:0] e_data;
        enc_end   = n + 1;
        dec_end   = 2 * n + 2;
        e_enc     = (k <= enc_end);
        e_dec     = (k > enc_end) && (k <= dec_end);
        e_done    = (k == dec_end + 1);
        e_round   = e_enc ? k - 1 : k - enc_end - 1;
        e_dec_run = e_dec || (e_enc && (k - 1 >= n + 1 - DEC_LEAD));
        e_match   = (k > dec_end) ? (dv == p) : 1'b0;
        e_data    = e_enc ? ev : dv;
        check("busy", busy, e_enc || e_dec);
        check("enc_run", enc_run, e_enc);
        check("dec_run", dec_run, e_dec_run);
        check("core_clr", core_clr, k == 1);
        check("done", done, e_done);
        check("err_idle", err, 0);
        check("nr", nr, n);
        check("match", match, e_match);
        check("data_out", data_out, e_data);
        check("byte_out", byte_out, e_data[8*byte_sel +: 8]);
        if (e_enc || e_dec) check("round", round, e_round);
    endtask

    task automatic do_run(input logic [1:0] m, input logic [DATA_W-1:0] p, input bit corrupt,
                          input bit noise, output int lat, output bit got_match, output bit got_err);
        logic [DATA_W-1:0] ev, dv;
        lat = 0;
        got_match = 1'b0;
        got_err = 1'b0;
        ev = '0;
        dv = '0;
        start = 1'b1;
        mode = m;
        plain_in = p;
        if (m != 2'd3) begin
            ev = {$urandom, $urandom, $urandom, $urandom};
            dv = corrupt ? (p ^ (128'd1 << $urandom_range(127, 0))) : p;
            enc_in = ev;
            dec_in = dv;
        end
        @(posedge clk); #1;
        start = 1'b0;
        if (m == 2'd3) begin
            got_err = err;
            check("rej_busy", busy, 0);
            check("rej_nr", nr, m_nr);
            check("rej_clr", core_clr, 0);
            check("rej_match", match, m_match);
            check("rej_data", data_out, m_in_done ? dec_in : m_plain);
            @(posedge clk); #1;
            check("rej_err_pulse", err, 0);
            check("rej_busy2", busy, 0);
            return;
        end
        m_nr = 10 + 2 * int'(m);
        m_plain = p;
        for (int k = 1; k <= 2 * m_nr + 4; k++) begin
            if (done && lat == 0) lat = k;
            check_cycle(k, m_nr, ev, dv, p);
            if (k == 2 * m_nr + 3) got_match = match;
            byte_sel = 4'($urandom_range(15, 0));
            if (noise && k <= 2 * m_nr + 2) begin
                start = 1'($urandom_range(1, 0));
                mode = 2'($urandom_range(3, 0));
                plain_in = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        m_match = (dv == p);
        m_in_done = 1'b1;
        if (m_match) m_pass++;
    endtask

    localparam logic [DATA_W-1:0] PT = 128'h00112233445566778899aabbccddeeff;

    initial begin
        vec_t vecs[6];
        int lat;
        bit gm, ge, seen_done;
        logic [DATA_W-1:0] pv;
        logic [1:0] rm;

        vecs[0] = '{2'd0, PT, 1'b0, 1'b0, 10, 1'b0, 1'b1, 23};
        vecs[1] = '{2'd2, PT, 1'b0, 1'b0, 14, 1'b0, 1'b1, 31};
        vecs[2] = '{2'd3, PT, 1'b0, 1'b0, 14, 1'b1, 1'b1, 0};
        vecs[3] = '{2'd1, PT, 1'b0, 1'b1, 12, 1'b0, 1'b1, 27};
        vecs[4] = '{2'd0, PT, 1'b1, 1'b1, 10, 1'b0, 1'b0, 23};
        vecs[5] = '{2'd2, 128'hdeadbeef_01234567_89abcdef_cafef00d, 1'b1, 1'b0, 14, 1'b0, 1'b0, 31};

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_nr", nr, 10);
        check("rst_round", round, 0);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_match", match, 0);
        check("idle_err", err, 0);
        check("idle_clr", core_clr, 0);
        check("idle_runs", {enc_run, dec_run}, 0);
        check("idle_nr", nr, 10);
        check("idle_data", data_out, 0);

        // A rejected request straight out of reset must leave everything idle.
        do_run(2'd3, PT, 1'b0, 1'b0, lat, gm, ge);
        check("rej_idle_err", ge, 1);

        for (int i = 0; i < 6; i++) begin
            do_run(vecs[i].mode, vecs[i].plain, vecs[i].corrupt, vecs[i].noise, lat, gm, ge);
            check($sformatf("vec%0d_nr", i), nr, vecs[i].exp_nr);
            check($sformatf("vec%0d_err", i), ge, vecs[i].exp_err);
            check($sformatf("vec%0d_match", i), match, vecs[i].exp_match);
            if (!vecs[i].exp_err) begin
                check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
                check($sformatf("vec%0d_gm", i), gm, vecs[i].exp_match);
            end
            if (i == 0) begin
                for (int b = 0; b < 16; b++) begin
                    byte_sel = 4'(b);
                    @(posedge clk); #1;
                    check($sformatf("byte%0d", b), byte_out, PT[8*b +: 8]);
                end
                byte_sel = 4'd0;
                @(posedge clk); #1;
                check("byte0_ff", byte_out, 8'hff);
            end
        end

        // Reset during DEC round 5 of an AES-256 run.
        start = 1'b1;
        mode = 2'd2;
        plain_in = PT;
        dec_in = PT;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k < 21; k++) begin
            @(posedge clk); #1;
        end
        check("pre_rst_round", round, 5);
        check("pre_rst_dec", {busy, dec_run, enc_run}, 3'b110);
        reset = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_runs", {enc_run, dec_run, core_clr}, 0);
        check("mid_rst_round", round, 0);
        check("mid_rst_nr", nr, 10);
        check("mid_rst_flags", {done, err, match}, 0);
        check("mid_rst_data", data_out, 0);
        seen_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done) seen_done = 1'b1;
        end
        check("mid_rst_no_done", seen_done, 0);
        reset = 1'b1;
        m_nr = 10;
        m_plain = '0;
        m_match = 1'b0;
        m_in_done = 1'b0;
        m_pass = 0;
        @(posedge clk); #1;
        check("post_rst_data", data_out, 0);

        for (int r = 0; r < 20; r++) begin
            rm = 2'($urandom_range(3, 0));
            pv = {$urandom, $urandom, $urandom, $urandom};
            do_run(rm, pv, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), lat, gm, ge);
            check("rnd_err", ge, rm == 2'd3);
            check("rnd_nr", nr, m_nr);
            if (rm != 2'd3) check("rnd_lat", lat, 2 * (10 + 2 * int'(rm)) + 3);
        end

`ifdef AES_RUN_PASS_CNT_EN
        check("pass_cnt", pass_cnt, m_pass);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
